// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
`timescale 1ns/1ps
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [1:0]  mf,
  output logic [31:0] HLOut,
  output logic        Busy,
  output logic        StallReq
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned CountW = 6;
  localparam int unsigned LastIter = DataW - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] opMult  = 3'b001;
  localparam logic [2:0] opMultu = 3'b010;
  localparam logic [2:0] opDiv   = 3'b011;
  localparam logic [2:0] opDivu  = 3'b100;
  localparam logic [2:0] opMthi  = 3'b101;
  localparam logic [2:0] opMtlo  = 3'b110;

  logic [1:0]          state, stateNext;
  logic [DataW-1:0]    hi, lo;
  logic [DataW:0]      accA;
  logic [DataW-1:0]    shQ, mReg;
  logic [CountW-1:0]   count;
  logic                negQ, negR, latchDiv, divZero;

  logic                isArith, isSigned, isDiv;
  logic [DataW-1:0]    absA, absB;
  logic [DataW:0]      multSum;
  logic [DataW:0]      divShift;
  logic [DataW+1:0]    divDiff;
  logic [2*DataW-1:0]  prod, prodFix;
  logic [DataW-1:0]    quotFix, remFix;

  // Operation decode
  always_comb begin
    isArith  = (Op == opMult) || (Op == opMultu) || (Op == opDiv) || (Op == opDivu);
    isSigned = (Op == opMult) || (Op == opDiv);
    isDiv    = (Op == opDiv)  || (Op == opDivu);
    absA     = (isSigned && SrcA[DataW-1]) ? DataW'(-SrcA) : SrcA;
    absB     = (isSigned && SrcB[DataW-1]) ? DataW'(-SrcB) : SrcB;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    multSum  = {1'b0, accA[DataW-1:0]} + (shQ[0] ? {1'b0, mReg} : (DataW+1)'(0));
    divShift = {accA[DataW-1:0], shQ[DataW-1]};
    divDiff  = {1'b0, divShift} - {2'b00, mReg};
  end

  // Sign correction applied in the FIX cycle
  always_comb begin
    prod    = {accA[DataW-1:0], shQ};
    prodFix = negQ ? (2*DataW)'(-prod) : prod;
    quotFix = negQ ? DataW'(-shQ) : shQ;
    remFix  = negR ? DataW'(-accA[DataW-1:0]) : accA[DataW-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start && isArith) stateNext = RUN;
      RUN:     if (count == CountW'(LastIter)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      accA     <= '0;
      shQ      <= '0;
      mReg     <= '0;
      count    <= '0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      latchDiv <= 1'b0;
      divZero  <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Busy <= (stateNext != IDLE);
      case (state)
        IDLE: begin
          if (Start) begin
            if (Op == opMthi) hi <= SrcA;
            if (Op == opMtlo) lo <= SrcA;
            if (isArith) begin
              accA     <= '0;
              shQ      <= absA;
              mReg     <= absB;
              count    <= '0;
              negQ     <= isSigned && (SrcA[DataW-1] ^ SrcB[DataW-1]);
              negR     <= (Op == opDiv) && SrcA[DataW-1];
              latchDiv <= isDiv;
              divZero  <= isDiv && (SrcB == '0);
            end
          end
        end
        RUN: begin
          count <= count + CountW'(1);
          if (latchDiv) begin
            // Keep the shifted remainder when the trial subtraction goes negative
            accA <= divDiff[DataW+1] ? divShift : divDiff[DataW:0];
            shQ  <= {shQ[DataW-2:0], ~divDiff[DataW+1]};
          end else begin
            accA <= {1'b0, multSum[DataW:1]};
            shQ  <= {multSum[0], shQ[DataW-1:1]};
          end
        end
        FIX: begin
          if (latchDiv) begin
            // With a zero divisor the remainder path restores the raw dividend
            hi <= remFix;
            lo <= divZero ? '1 : quotFix;
          end else begin
            hi <= prodFix[2*DataW-1:DataW];
            lo <= prodFix[DataW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign HLOut    = (mf == 2'b10) ? hi : (mf == 2'b11) ? lo : '0;
  assign StallReq = Busy & (Start | mf[1]);

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with HI/LO registers for the execute stage of the pipelined MIPS core. It consumes the forwarded execute operands (SrcAE, SrcBE) and produces the mfhi/mflo result that feeds the execute-stage result mux. It replaces single-cycle HI/LO arithmetic with a 33-cycle sequential engine. While the engine runs, it raises a stall request to the hazard unit.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  execute stage holds a valid HI/LO-writing op this cycle; the pipeline is not flushed
- Op  in  3  operation code
  - 001 mult, 010 multu, 011 div, 100 divu
  - 101 mthi, 110 mtlo
  - other codes: no-op
- SrcA  in  32  rs operand after forwarding
- SrcB  in  32  rt operand after forwarding
- mf  in  2  read select: 10 mfhi, 11 mflo, 0x none
- HLOut  out  32  combinational read: HI when mf=10, LO when mf=11, 0 otherwise
- Busy  out  1  engine running (registered)
- StallReq  out  1  combinational: Busy & (Start | mf[1]); to the hazard unit (StallF/StallD, FlushE)

## Operation
- Registers:
  - HI, LO (32 each)
  - accumulator/remainder A (33), shift register Q (32), divisor/multiplicand M (32)
  - count (6), sign flags negQ and negR, op latch
- States: IDLE, RUN, FIX.
- IDLE:
  - Start with mthi/mtlo writes SrcA to HI/LO at this edge; stays IDLE; Busy stays 0.
  - Start with mult/multu/div/divu loads the operands at this edge and goes to RUN with count=0.
    - Operands are taken as magnitudes for signed ops.
    - negQ = SrcA[31]^SrcB[31] for signed ops, else 0.
    - negR = SrcA[31] for div, else 0.
  - Any other Op code with Start: no effect.
- RUN (32 edges; count increments 0..31; leave to FIX when count=31):
  - mult/multu: shift-add, one multiplier bit per cycle, LSB first.
  - div/divu: restoring division, one quotient bit per cycle, MSB first.
- FIX (1 edge), then to IDLE:
  - Writes HI/LO. Signed results are negated per negQ (64-bit product, or quotient) and negR (remainder).
  - mult/multu: HI = upper 32 bits, LO = lower 32 bits of the 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero (SrcB=0 at start), div or divu:
  - HI = SrcA (raw), LO = 32'hFFFFFFFF.
  - Latency unchanged; no exception.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- Start while Busy: ignored; no state change. StallReq holds the requester in E so it is reissued.
- mf while Busy: HLOut shows the old HI/LO; StallReq=1 until Busy falls.

## Timing
- Reset values:
  - HI=0, LO=0, Busy=0, state IDLE, count=0, A/Q/M=0.
  - HLOut=0 unless mf selects; StallReq=0.
- Reset in RUN or FIX aborts the op; no HI/LO update survives.
- Start sampled at edge E0:
  - Busy=1 after E0.
  - RUN covers edges E1..E32; FIX at edge E33 writes HI/LO.
  - Busy=0 after E33.
  - Busy is high for exactly 33 cycles.
- A dependent mfhi/mflo is released the cycle after E33 and reads the new value combinationally.
- mthi/mtlo: HI/LO updated at the Start edge; visible on HLOut the next cycle.
- A new mult/div is accepted at the first edge where state=IDLE, so back-to-back ops are spaced 34 edges apart.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN of a mult -> Busy=0, HI=LO=0, HLOut=0 with mf=10 and mf=11.
- multu SrcA=32'hFFFFFFFF, SrcB=2:
  - Busy high 33 cycles.
  - Then HI=32'h00000001, LO=32'hFFFFFFFE.
- mult SrcA=-3, SrcB=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
- div SrcA=-7, SrcB=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- divu SrcA=32'h12345678, SrcB=0:
  - HI=32'h12345678, LO=32'hFFFFFFFF after 33 cycles.
- mthi 32'hCAFEF00D, then immediately mult 4*4 with mf=10 asserted:
  - StallReq=1 throughout Busy.
  - HLOut=32'hCAFEF00D until FIX, then HI=0 and LO=16.
  - A Start issued mid-run is ignored.
